// File: rtl/rst_sequencer_if.sv
// rtl/rst_sequencer_if.sv - lock/sw-reset inputs and reset/status outputs of the reset sequencer
interface rst_sequencer_if;
    logic       i_locked;
    logic       i_sw_rst;
    logic       o_rst_core;
    logic       o_rst_hdmi;
    logic       o_ready;
    logic [2:0] o_state;

    // Controller side: owns the clocking-wizard lock and the software request
    modport master (
        output i_locked,
        output i_sw_rst,
        input  o_rst_core,
        input  o_rst_hdmi,
        input  o_ready,
        input  o_state
    );

    // Sequencer side
    modport slave (
        input  i_locked,
        input  i_sw_rst,
        output o_rst_core,
        output o_rst_hdmi,
        output o_ready,
        output o_state
    );
endinterface

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - lock-qualified staged release of core and HDMI resets
module rst_sequencer #(
    parameter int P_LOCK_CYC = 16,
    parameter int P_CORE_DLY = 8,
    parameter int P_HDMI_DLY = 8,
    parameter int P_CNT_W    = 8
) (
    input  logic          i_sclk,
    input  logic          i_srst,
    rst_sequencer_if.slave bus
);

    localparam logic [2:0] S_WAIT_LOCK = 3'd0;
    localparam logic [2:0] S_HOLD      = 3'd1;
    localparam logic [2:0] S_CORE_UP   = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;

    // Terminal counts: the counter stops at parameter-1, so it can never wrap
    localparam logic [P_CNT_W-1:0] L_LOCK_LAST = P_CNT_W'(P_LOCK_CYC - 1);
    localparam logic [P_CNT_W-1:0] L_CORE_LAST = P_CNT_W'(P_CORE_DLY - 1);
    localparam logic [P_CNT_W-1:0] L_HDMI_LAST = P_CNT_W'(P_HDMI_DLY - 1);
    localparam logic [P_CNT_W-1:0] L_ONE       = P_CNT_W'(1);
    localparam logic [P_CNT_W-1:0] L_ZERO      = '0;

    logic               lock_m;
    logic               lock_s;
    logic [2:0]         state;
    logic [2:0]         nxt_state;
    logic [P_CNT_W-1:0] cnt;
    logic [P_CNT_W-1:0] nxt_cnt;
    logic               rst_core_q;
    logic               rst_hdmi_q;
    logic               ready_q;
    logic [2:0]         state_q;

    // Two-flop synchronizer bringing the asynchronous lock into i_sclk
    always_ff @(posedge i_sclk) begin
        if (i_srst) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= bus.i_locked;
            lock_s <= lock_m;
        end
    end

    // Next state/counter; lock loss outranks the software request, normal flow is last
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        case (state)
            S_WAIT_LOCK: begin
                if (!lock_s) begin
                    nxt_cnt = L_ZERO;
                end else if (cnt == L_LOCK_LAST) begin
                    nxt_state = S_HOLD;
                    nxt_cnt   = L_ZERO;
                end else begin
                    nxt_cnt = cnt + L_ONE;
                end
            end
            S_HOLD: begin
                if (cnt == L_CORE_LAST) begin
                    nxt_state = S_CORE_UP;
                    nxt_cnt   = L_ZERO;
                end else begin
                    nxt_cnt = cnt + L_ONE;
                end
            end
            S_CORE_UP: begin
                if (cnt == L_HDMI_LAST) begin
                    nxt_state = S_RUN;
                    nxt_cnt   = L_ZERO;
                end else begin
                    nxt_cnt = cnt + L_ONE;
                end
            end
            S_RUN: begin
                nxt_cnt = L_ZERO;
            end
            default: begin
                nxt_state = S_WAIT_LOCK;
                nxt_cnt   = L_ZERO;
            end
        endcase

        if (!lock_s || bus.i_sw_rst) begin
            nxt_state = S_WAIT_LOCK;
            nxt_cnt   = L_ZERO;
        end
    end

    // State register with outputs decoded from the next state so both move on one edge
    always_ff @(posedge i_sclk) begin
        if (i_srst) begin
            state      <= S_WAIT_LOCK;
            cnt        <= L_ZERO;
            rst_core_q <= 1'b1;
            rst_hdmi_q <= 1'b1;
            ready_q    <= 1'b0;
            state_q    <= S_WAIT_LOCK;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            rst_core_q <= !((nxt_state == S_CORE_UP) || (nxt_state == S_RUN));
            rst_hdmi_q <= (nxt_state != S_RUN);
            ready_q    <= (nxt_state == S_RUN);
            state_q    <= nxt_state;
        end
    end

    assign bus.o_rst_core = rst_core_q;
    assign bus.o_rst_hdmi = rst_hdmi_q;
    assign bus.o_ready    = ready_q;
    assign bus.o_state    = state_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb/tb_rst_sequencer.sv - self-checking bench for rst_sequencer
module tb_rst_sequencer;

    localparam int L = 16;
    localparam int C = 8;
    localparam int H = 8;
    localparam int MAXS = L + C + H;

    logic clk = 1'b0;
    logic srst;
    logic srst2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the sequence is a function of how many consecutive edges
    // have seen a synchronized lock with no software request and no reset.
    int m_s1, m_s2, m_streak;

    rst_sequencer_if u_if ();
    rst_sequencer_if u_if2 ();

    rst_sequencer #(.P_LOCK_CYC(L), .P_CORE_DLY(C), .P_HDMI_DLY(H), .P_CNT_W(8)) u_dut (
        .i_sclk (clk),
        .i_srst (srst),
        .bus    (u_if)
    );

    rst_sequencer #(.P_LOCK_CYC(1), .P_CORE_DLY(1), .P_HDMI_DLY(1), .P_CNT_W(4)) u_dut_min (
        .i_sclk (clk),
        .i_srst (srst2),
        .bus    (u_if2)
    );

    always #5 clk = ~clk;

    function automatic int exp_state(input int s);
        if (s < L)          return 0;
        else if (s < L + C) return 1;
        else if (s < MAXS)  return 2;
        else                return 3;
    endfunction

    // One clock edge; the model advances with the same inputs the DUT samples
    task automatic tick();
        @(posedge clk);
        if (srst) begin
            m_s1 = 0;
            m_s2 = 0;
            m_streak = 0;
        end else begin
            if (m_s2 == 0 || u_if.i_sw_rst) m_streak = 0;
            else if (m_streak < MAXS) m_streak = m_streak + 1;
            m_s2 = m_s1;
            m_s1 = int'(u_if.i_locked);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        srst = 1'b1;
        u_if.i_locked = 1'b0;
        u_if.i_sw_rst = 1'b0;
        repeat (3) tick();
        srst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (u_if.o_state !== 3'd0 || u_if.o_rst_core !== 1'b1 || u_if.o_rst_hdmi !== 1'b1 || u_if.o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: state=%0d core=%b hdmi=%b ready=%b required 0 1 1 0",
                     u_if.o_state, u_if.o_rst_core, u_if.o_rst_hdmi, u_if.o_ready);
        end
    endtask

    task automatic test_nominal();
        int e_hold, e_core, e_run;
        e_hold = 0; e_core = 0; e_run = 0;
        do_reset();
        u_if.i_locked = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            n_checks++;
            if (int'(u_if.o_state) != exp_state(m_streak)) begin
                n_fail++;
                $display("FAIL nominal_state edge %0d: got %0d required %0d", e, u_if.o_state, exp_state(m_streak));
            end
            if (e_hold == 0 && u_if.o_state == 3'd1) e_hold = e;
            if (e_core == 0 && u_if.o_rst_core == 1'b0) e_core = e;
            if (e_run == 0 && u_if.o_ready == 1'b1 && u_if.o_rst_hdmi == 1'b0) e_run = e;
        end
        n_checks++;
        if (e_hold != 18) begin n_fail++; $display("FAIL nominal_hold_edge: got %0d required 18", e_hold); end
        n_checks++;
        if (e_core != 26) begin n_fail++; $display("FAIL nominal_core_edge: got %0d required 26", e_core); end
        n_checks++;
        if (e_run != 34) begin n_fail++; $display("FAIL nominal_run_edge: got %0d required 34", e_run); end
    endtask

    task automatic test_lock_glitch();
        int e_run;
        e_run = 0;
        do_reset();
        u_if.i_locked = 1'b1;
        repeat (12) tick();
        u_if.i_locked = 1'b0;
        tick();
        u_if.i_locked = 1'b1;
        for (int e = 14; e <= 60; e++) begin
            tick();
            n_checks++;
            if (int'(u_if.o_state) != exp_state(m_streak)) begin
                n_fail++;
                $display("FAIL glitch_state edge %0d: got %0d required %0d", e, u_if.o_state, exp_state(m_streak));
            end
            if (e_run == 0 && u_if.o_ready == 1'b1) e_run = e;
        end
        n_checks++;
        if (e_run != 47) begin n_fail++; $display("FAIL glitch_ready_edge: got %0d required 47", e_run); end
    endtask

    task automatic test_run_lock_loss();
        int e_run;
        e_run = 0;
        do_reset();
        u_if.i_locked = 1'b1;
        repeat (34) tick();
        n_checks++;
        if (u_if.o_ready !== 1'b1) begin n_fail++; $display("FAIL loss_in_run: ready=%b required 1", u_if.o_ready); end
        u_if.i_locked = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (u_if.o_ready !== 1'b1) begin n_fail++; $display("FAIL loss_sync_delay: ready=%b required 1", u_if.o_ready); end
        tick();
        n_checks++;
        if (u_if.o_ready !== 1'b0 || u_if.o_state !== 3'd0 || u_if.o_rst_core !== 1'b1 || u_if.o_rst_hdmi !== 1'b1) begin
            n_fail++;
            $display("FAIL loss_drop: state=%0d core=%b hdmi=%b ready=%b required 0 1 1 0",
                     u_if.o_state, u_if.o_rst_core, u_if.o_rst_hdmi, u_if.o_ready);
        end
        u_if.i_locked = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (e_run == 0 && u_if.o_ready == 1'b1) e_run = e;
        end
        n_checks++;
        if (e_run != 34) begin n_fail++; $display("FAIL relock_ready_edge: got %0d required 34", e_run); end
    endtask

    task automatic test_sw_rst();
        int e_run;
        e_run = 0;
        do_reset();
        u_if.i_locked = 1'b1;
        repeat (28) tick();
        n_checks++;
        if (u_if.o_state !== 3'd2) begin n_fail++; $display("FAIL swrst_core_up: state=%0d required 2", u_if.o_state); end
        u_if.i_sw_rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (u_if.o_state !== 3'd0 || u_if.o_rst_core !== 1'b1) begin
                n_fail++;
                $display("FAIL swrst_hold cycle %0d: state=%0d core=%b required 0 1", i, u_if.o_state, u_if.o_rst_core);
            end
        end
        u_if.i_sw_rst = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (e_run == 0 && u_if.o_ready == 1'b1) e_run = e;
        end
        n_checks++;
        if (e_run != 32) begin n_fail++; $display("FAIL swrst_ready_edge: got %0d required 32", e_run); end
    endtask

    task automatic test_srst_priority();
        do_reset();
        u_if.i_locked = 1'b1;
        repeat (36) tick();
        srst = 1'b1;
        u_if.i_sw_rst = 1'b1;
        u_if.i_locked = 1'b0;
        tick();
        n_checks++;
        if (u_if.o_state !== 3'd0 || u_if.o_rst_core !== 1'b1 || u_if.o_rst_hdmi !== 1'b1 || u_if.o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL srst_priority: state=%0d core=%b hdmi=%b ready=%b required 0 1 1 0",
                     u_if.o_state, u_if.o_rst_core, u_if.o_rst_hdmi, u_if.o_ready);
        end
        srst = 1'b0;
        u_if.i_sw_rst = 1'b0;
    endtask

    task automatic test_random();
        int exp;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 4) u_if.i_locked = ~u_if.i_locked;
            if ($urandom_range(0, 99) < 15 && u_if.i_locked == 1'b0) u_if.i_locked = 1'b1;
            u_if.i_sw_rst = ($urandom_range(0, 199) == 0);
            srst = ($urandom_range(0, 399) == 0);
            tick();
            exp = exp_state(m_streak);
            n_checks++;
            if (int'(u_if.o_state) != exp || u_if.o_rst_core !== (exp < 2) || u_if.o_rst_hdmi !== (exp != 3) || u_if.o_ready !== (exp == 3)) begin
                n_fail++;
                $display("FAIL random cycle %0d: state=%0d core=%b hdmi=%b ready=%b required state %0d",
                         i, u_if.o_state, u_if.o_rst_core, u_if.o_rst_hdmi, u_if.o_ready, exp);
            end
            n_checks++;
            if (u_if.o_rst_core === 1'b1 && u_if.o_rst_hdmi === 1'b0) begin
                n_fail++;
                $display("FAIL random_order cycle %0d: core=1 hdmi=0 required hdmi held while core in reset", i);
            end
        end
        srst = 1'b0;
        u_if.i_sw_rst = 1'b0;
    endtask

    task automatic test_min_params();
        int e_run;
        e_run = 0;
        srst2 = 1'b1;
        u_if2.i_locked = 1'b0;
        u_if2.i_sw_rst = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (u_if2.o_ready !== 1'b0 || u_if2.o_rst_core !== 1'b1) begin
            n_fail++;
            $display("FAIL min_reset: ready=%b core=%b required 0 1", u_if2.o_ready, u_if2.o_rst_core);
        end
        srst2 = 1'b0;
        u_if2.i_locked = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e_run == 0 && u_if2.o_ready == 1'b1) e_run = e;
        end
        n_checks++;
        if (e_run != 5) begin n_fail++; $display("FAIL min_ready_edge: got %0d required 5", e_run); end
    endtask

    initial begin
        srst = 1'b1;
        srst2 = 1'b1;
        u_if.i_locked = 1'b0;
        u_if.i_sw_rst = 1'b0;
        u_if2.i_locked = 1'b0;
        u_if2.i_sw_rst = 1'b0;
        m_s1 = 0;
        m_s2 = 0;
        m_streak = 0;
        @(negedge clk);
        test_reset();
        test_nominal();
        test_lock_glitch();
        test_run_lock_loss();
        test_sw_rst();
        test_srst_priority();
        test_random();
        test_min_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 Parameter P_LOCK_CYC, default 16: consecutive synchronized-lock cycles required before sequencing starts.
REQ-002 Parameter P_CORE_DLY, default 8: cycles in HOLD before core reset release.
REQ-003 Parameter P_HDMI_DLY, default 8: cycles between core reset release and HDMI reset release.
REQ-004 Parameter P_CNT_W, default 8: counter width; each delay parameter SHALL be in 1..2^P_CNT_W.
REQ-005 i_sclk  input  1  single system clock; all logic on rising edge.
REQ-006 i_srst  input  1  reset, synchronous, active-high (driven by the async-to-sync reset bridge).
REQ-007 i_locked  input  1  clocking-wizard lock, asynchronous to i_sclk.
REQ-008 i_sw_rst  input  1  software re-sequence request, synchronous, level-sensitive.
REQ-009 o_rst_core  output  1  active-high reset to core logic.
REQ-010 o_rst_hdmi  output  1  active-high reset to HDMI/TMDS logic.
REQ-011 o_ready  output  1  high when all resets released.
REQ-012 o_state  output  3  current state encoding, for debug.

Function
REQ-013 i_locked SHALL pass a 2-flop synchronizer (flops reset to 0); its output is lock_s.
REQ-014 States and o_state encoding: WAIT_LOCK=0, HOLD=1, CORE_UP=2, RUN=3; codes 4-7 unused, SHALL go to WAIT_LOCK.
REQ-015 One counter cnt (P_CNT_W bits), cleared to 0 on every state entry.
REQ-016 WAIT_LOCK: lock_s=1 -> cnt+1; lock_s=0 -> cnt=0; lock_s=1 with cnt==P_LOCK_CYC-1 -> HOLD.
REQ-017 HOLD: cnt+1 per cycle; cnt==P_CORE_DLY-1 -> CORE_UP.
REQ-018 CORE_UP: cnt+1 per cycle; cnt==P_HDMI_DLY-1 -> RUN.
REQ-019 RUN: holds indefinitely; cnt frozen at 0.
REQ-020 lock_s=0 in HOLD, CORE_UP or RUN -> WAIT_LOCK on that edge.
REQ-021 i_sw_rst=1 in any state -> WAIT_LOCK, cnt=0; sequence restarts only after i_sw_rst returns to 0.
REQ-022 Priority per edge: i_srst > lock loss > i_sw_rst > normal transition.
REQ-023 Outputs SHALL be registered and updated on the same edge as the state register: o_rst_core=0 only in CORE_UP/RUN; o_rst_hdmi=0 only in RUN; o_ready=1 only in RUN.
REQ-024 o_rst_core SHALL never be 0 while o_rst_hdmi is 0 unless both released in order (core never reasserted after hdmi release without hdmi reasserting on the same edge).
REQ-025 Counter SHALL never wrap; compare values limit it to parameter-1.

Reset
REQ-026 i_srst=1 on an edge: state=WAIT_LOCK, cnt=0, sync flops=0, o_rst_core=1, o_rst_hdmi=1, o_ready=0, o_state=0.
REQ-027 Reset mid-sequence (any state) SHALL take effect at the next edge with identical values to REQ-026.
REQ-028 No asynchronous reset path; power-up values equal reset values.

Verification
REQ-029 Defaults, i_srst released, i_locked=1 from edge 1 -> HOLD at edge 18, o_rst_core falls at edge 26, o_rst_hdmi falls and o_ready rises at edge 34.
REQ-030 i_locked low 1 cycle during WAIT_LOCK count at cnt=10 -> cnt restarts; o_ready delayed by the lost cycles plus glitch length.
REQ-031 In RUN, i_locked falls -> 2 edges later lock_s=0; next edge both resets=1, o_ready=0, o_state=0; relock repeats REQ-029 timing.
REQ-032 In CORE_UP, i_sw_rst held 5 cycles -> WAIT_LOCK next edge, o_rst_core=1, state held 0 for 5 cycles, full sequence after release.
REQ-033 i_srst asserted with i_sw_rst and lock loss same edge in RUN -> reset values of REQ-026; P_LOCK_CYC=P_CORE_DLY=P_HDMI_DLY=1 -> o_ready 5 edges after i_locked sampled high.
